// File: rtl/alu_imm_iq_multi_pkg.sv
// Writeback-bus types and forwarding helpers for the multi-enqueue ALU reg-imm issue queue.
package alu_imm_iq_multi_pkg;

    import core_types_pkg::*;

    localparam int unsigned WB_UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef logic [PRF_BANK_COUNT-1:0][WB_UPPER_W-1:0] wb_upper_t;

    function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input logic [LOG_PR_COUNT-1:0] pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

    // A PR is being written this cycle when its bank's writeback carries the same upper bits.
    function automatic logic fwd_hit(input logic [LOG_PR_COUNT-1:0]   pr,
                                     input logic [PRF_BANK_COUNT-1:0] wb_valid,
                                     input wb_upper_t                 wb_upper);
        logic [LOG_PRF_BANK_COUNT-1:0] bank;
        bank = pr_bank(pr);
        return wb_valid[bank] && (wb_upper[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
    endfunction

endpackage

// File: rtl/core_types_pkg.sv
// Core-wide widths and the ALU reg-imm issue queue entry payload.
package core_types_pkg;

    localparam int unsigned LOG_PR_COUNT       = 7;
    localparam int unsigned LOG_ROB_ENTRIES    = 5;
    localparam int unsigned PRF_BANK_COUNT     = 4;
    localparam int unsigned LOG_PRF_BANK_COUNT = 2;

    typedef struct packed {
        logic [3:0]                 op;
        logic [11:0]                imm12;
        logic [LOG_PR_COUNT-1:0]    A_PR;
        logic                       A_ready;
        logic                       A_is_zero;
        logic [LOG_PR_COUNT-1:0]    dest_PR;
        logic [LOG_ROB_ENTRIES-1:0] ROB_index;
    } alu_imm_iq_entry_t;

endpackage

// File: rtl/alu_imm_iq_multi_if.sv
// Dispatch, writeback, kill and issue signals of the ALU reg-imm issue queue.
interface alu_imm_iq_multi_if #(
    parameter int unsigned IQ_ENTRIES = 12,
    parameter int unsigned ENQ_WIDTH  = 2
);
    import core_types_pkg::*;
    import alu_imm_iq_multi_pkg::*;

    localparam int unsigned OCC_W = $clog2(IQ_ENTRIES + 1);

    logic [ENQ_WIDTH-1:0]                      iq_enq_valid;
    logic [ENQ_WIDTH-1:0][3:0]                 iq_enq_op;
    logic [ENQ_WIDTH-1:0][11:0]                iq_enq_imm12;
    logic [ENQ_WIDTH-1:0][LOG_PR_COUNT-1:0]    iq_enq_A_PR;
    logic [ENQ_WIDTH-1:0]                      iq_enq_A_ready;
    logic [ENQ_WIDTH-1:0]                      iq_enq_A_is_zero;
    logic [ENQ_WIDTH-1:0][LOG_PR_COUNT-1:0]    iq_enq_dest_PR;
    logic [ENQ_WIDTH-1:0][LOG_ROB_ENTRIES-1:0] iq_enq_ROB_index;
    logic [ENQ_WIDTH-1:0]                      iq_enq_ready;
    logic [OCC_W-1:0]                          iq_occupancy;

    logic [PRF_BANK_COUNT-1:0]                 WB_bus_valid_by_bank;
    wb_upper_t                                 WB_bus_upper_PR_by_bank;

    logic [LOG_ROB_ENTRIES-1:0]                rob_head_index;
    logic                                      kill_valid;
    logic [LOG_ROB_ENTRIES-1:0]                kill_ROB_index;

    logic                                      issue_valid;
    logic [3:0]                                issue_op;
    logic [11:0]                               issue_imm12;
    logic                                      issue_A_forward;
    logic                                      issue_A_is_zero;
    logic [LOG_PRF_BANK_COUNT-1:0]             issue_A_bank;
    logic [LOG_PR_COUNT-1:0]                   issue_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]                issue_ROB_index;
    logic                                      issue_ready;
    logic                                      PRF_req_A_valid;
    logic [LOG_PR_COUNT-1:0]                   PRF_req_A_PR;

    modport master (
        output iq_enq_valid, iq_enq_op, iq_enq_imm12, iq_enq_A_PR, iq_enq_A_ready,
               iq_enq_A_is_zero, iq_enq_dest_PR, iq_enq_ROB_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank,
               rob_head_index, kill_valid, kill_ROB_index, issue_ready,
        input  iq_enq_ready, iq_occupancy,
               issue_valid, issue_op, issue_imm12, issue_A_forward, issue_A_is_zero,
               issue_A_bank, issue_dest_PR, issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR
    );

    modport slave (
        input  iq_enq_valid, iq_enq_op, iq_enq_imm12, iq_enq_A_PR, iq_enq_A_ready,
               iq_enq_A_is_zero, iq_enq_dest_PR, iq_enq_ROB_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank,
               rob_head_index, kill_valid, kill_ROB_index, issue_ready,
        output iq_enq_ready, iq_occupancy,
               issue_valid, issue_op, issue_imm12, issue_A_forward, issue_A_is_zero,
               issue_A_bank, issue_dest_PR, issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR
    );

endinterface

// File: rtl/pe_lsb.sv
// Priority encoder: index of the lowest set request bit.
module pe_lsb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) idx_c = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rob_age_kill_cmp.sv
// Per-entry kill decision: entry dies when it is no older than the kill point, ages taken from the ROB head.
module rob_age_kill_cmp
    import core_types_pkg::*;
(
    input  logic                       entry_valid,
    input  logic [LOG_ROB_ENTRIES-1:0] rob_index,
    input  logic [LOG_ROB_ENTRIES-1:0] rob_head_index,
    input  logic                       kill_valid,
    input  logic [LOG_ROB_ENTRIES-1:0] kill_rob_index,
    output logic                       kill_c
);

    logic [LOG_ROB_ENTRIES-1:0] entry_age;
    logic [LOG_ROB_ENTRIES-1:0] kill_age;

    always_comb begin
        entry_age = LOG_ROB_ENTRIES'(rob_index - rob_head_index);
        kill_age  = LOG_ROB_ENTRIES'(kill_rob_index - rob_head_index);
        kill_c    = entry_valid & kill_valid & (entry_age >= kill_age);
    end

endmodule

// File: rtl/alu_imm_iq_multi.sv
// Compacting, age-ordered ALU reg-imm issue queue: ENQ_WIDTH dispatches in, one oldest-ready issue out per cycle.
module alu_imm_iq_multi
    import core_types_pkg::*;
    import alu_imm_iq_multi_pkg::*;
#(
    parameter int unsigned IQ_ENTRIES = 12,
    parameter int unsigned ENQ_WIDTH  = 2
) (
    input logic               CLK,
    input logic               nRST,
    alu_imm_iq_multi_if.slave iq
);

    localparam int unsigned OCC_W = $clog2(IQ_ENTRIES + 1);
    localparam int unsigned IDX_W = $clog2(IQ_ENTRIES);

    alu_imm_iq_entry_t       entry_q     [IQ_ENTRIES];
    logic [IQ_ENTRIES-1:0]   valid_q;
    alu_imm_iq_entry_t       entry_d     [IQ_ENTRIES];
    logic [IQ_ENTRIES-1:0]   valid_d;

    logic [OCC_W-1:0]        occ_c;
    int unsigned             free_slots_c;
    logic [ENQ_WIDTH-1:0]    enq_ready_c;
    logic [ENQ_WIDTH-1:0]    enq_accept_c;
    logic [IQ_ENTRIES-1:0]   kill_c;
    logic [IQ_ENTRIES-1:0]   ready_c;
    logic [IQ_ENTRIES-1:0]   req_c;
    logic                    sel_valid_c;
    logic [IDX_W-1:0]        sel_idx_c;
    alu_imm_iq_entry_t       sel_entry_c;
    logic                    sel_fwd_c;
    alu_imm_iq_entry_t       pre_entry_c [IQ_ENTRIES+1];
    logic [IQ_ENTRIES:0]     pre_valid_c;
    logic [OCC_W-1:0]        slot_c;

    // Dispatch credit comes only from registered state.
    always_comb begin
        occ_c        = OCC_W'($countones(valid_q));
        free_slots_c = IQ_ENTRIES - 32'(occ_c);
        for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
            enq_ready_c[k] = free_slots_c > 32'(k);
        end
        iq.iq_enq_ready = enq_ready_c;
        iq.iq_occupancy = occ_c;
    end

    for (genvar i = 0; i < IQ_ENTRIES; i++) begin : g_kill
        rob_age_kill_cmp u_kill_cmp (
            .entry_valid    (valid_q[i]),
            .rob_index      (entry_q[i].ROB_index),
            .rob_head_index (iq.rob_head_index),
            .kill_valid     (iq.kill_valid),
            .kill_rob_index (iq.kill_ROB_index),
            .kill_c         (kill_c[i])
        );
    end

    always_comb begin
        for (int i = 0; i < int'(IQ_ENTRIES); i++) begin
            ready_c[i] = valid_q[i] & ~kill_c[i]
                       & (entry_q[i].A_ready | entry_q[i].A_is_zero
                          | fwd_hit(entry_q[i].A_PR, iq.WB_bus_valid_by_bank, iq.WB_bus_upper_PR_by_bank));
        end
        req_c = ready_c & {IQ_ENTRIES{iq.issue_ready}};
    end

    pe_lsb #(.WIDTH(IQ_ENTRIES), .IDX_W(IDX_W)) u_issue_sel (
        .req     (req_c),
        .valid_c (sel_valid_c),
        .idx_c   (sel_idx_c)
    );

    always_comb begin
        sel_entry_c        = entry_q[sel_idx_c];
        sel_fwd_c          = fwd_hit(sel_entry_c.A_PR, iq.WB_bus_valid_by_bank, iq.WB_bus_upper_PR_by_bank);
        iq.issue_valid     = sel_valid_c;
        iq.issue_op        = sel_entry_c.op;
        iq.issue_imm12     = sel_entry_c.imm12;
        iq.issue_A_forward = sel_fwd_c;
        iq.issue_A_is_zero = sel_entry_c.A_is_zero;
        iq.issue_A_bank    = pr_bank(sel_entry_c.A_PR);
        iq.issue_dest_PR   = sel_entry_c.dest_PR;
        iq.issue_ROB_index = sel_entry_c.ROB_index;
        iq.PRF_req_A_valid = sel_valid_c & ~sel_fwd_c & ~sel_entry_c.A_is_zero;
        iq.PRF_req_A_PR    = sel_entry_c.A_PR;
    end

    // Build the pre-issue image (survivors plus dispatched lanes), then close the issued hole.
    always_comb begin
        pre_valid_c = '0;
        slot_c      = '0;
        for (int i = 0; i <= int'(IQ_ENTRIES); i++) pre_entry_c[i] = '0;
        for (int i = 0; i < int'(IQ_ENTRIES); i++) begin
            pre_valid_c[i] = valid_q[i] & ~kill_c[i];
            pre_entry_c[i] = entry_q[i];
        end
        for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
            enq_accept_c[k] = iq.iq_enq_valid[k] & enq_ready_c[k] & ~iq.kill_valid;
            if (enq_accept_c[k]) begin
                slot_c                        = occ_c + OCC_W'(k);
                pre_valid_c[slot_c]           = 1'b1;
                pre_entry_c[slot_c].op        = iq.iq_enq_op[k];
                pre_entry_c[slot_c].imm12     = iq.iq_enq_imm12[k];
                pre_entry_c[slot_c].A_PR      = iq.iq_enq_A_PR[k];
                pre_entry_c[slot_c].A_ready   = iq.iq_enq_A_ready[k];
                pre_entry_c[slot_c].A_is_zero = iq.iq_enq_A_is_zero[k];
                pre_entry_c[slot_c].dest_PR   = iq.iq_enq_dest_PR[k];
                pre_entry_c[slot_c].ROB_index = iq.iq_enq_ROB_index[k];
            end
        end
        for (int i = 0; i < int'(IQ_ENTRIES); i++) begin
            if (sel_valid_c && (IDX_W'(i) >= sel_idx_c)) begin
                valid_d[i] = pre_valid_c[i+1];
                entry_d[i] = pre_entry_c[i+1];
            end else begin
                valid_d[i] = pre_valid_c[i];
                entry_d[i] = pre_entry_c[i];
            end
            entry_d[i].A_ready = entry_d[i].A_ready
                               | fwd_hit(entry_d[i].A_PR, iq.WB_bus_valid_by_bank, iq.WB_bus_upper_PR_by_bank);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(IQ_ENTRIES); i++) entry_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(IQ_ENTRIES); i++) entry_q[i] <= entry_d[i];
        end
    end

endmodule

// File: tb/tb_alu_imm_iq_multi.sv
// Directed bench for the multi-enqueue ALU reg-imm issue queue.
module tb_alu_imm_iq_multi;
    import core_types_pkg::*;

    localparam int unsigned IQ_ENTRIES = 12;
    localparam int unsigned ENQ_WIDTH  = 2;

    logic CLK = 1'b0;
    logic nRST;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_imm_iq_multi_if #(.IQ_ENTRIES(IQ_ENTRIES), .ENQ_WIDTH(ENQ_WIDTH)) iq ();

    alu_imm_iq_multi #(.IQ_ENTRIES(IQ_ENTRIES), .ENQ_WIDTH(ENQ_WIDTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .iq   (iq)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iq.iq_enq_valid            = '0;
        iq.iq_enq_op               = '0;
        iq.iq_enq_imm12            = '0;
        iq.iq_enq_A_PR             = '0;
        iq.iq_enq_A_ready          = '0;
        iq.iq_enq_A_is_zero        = '0;
        iq.iq_enq_dest_PR          = '0;
        iq.iq_enq_ROB_index        = '0;
        iq.WB_bus_valid_by_bank    = '0;
        iq.WB_bus_upper_PR_by_bank = '0;
        iq.rob_head_index          = '0;
        iq.kill_valid              = 1'b0;
        iq.kill_ROB_index          = '0;
        iq.issue_ready             = 1'b0;
    endtask

    task automatic set_lane(input logic k, input logic [3:0] op, input logic [11:0] imm,
                            input logic [LOG_PR_COUNT-1:0] a_pr, input logic a_rdy, input logic a_zero,
                            input logic [LOG_PR_COUNT-1:0] dest, input logic [LOG_ROB_ENTRIES-1:0] rob);
        iq.iq_enq_valid[k]     = 1'b1;
        iq.iq_enq_op[k]        = op;
        iq.iq_enq_imm12[k]     = imm;
        iq.iq_enq_A_PR[k]      = a_pr;
        iq.iq_enq_A_ready[k]   = a_rdy;
        iq.iq_enq_A_is_zero[k] = a_zero;
        iq.iq_enq_dest_PR[k]   = dest;
        iq.iq_enq_ROB_index[k] = rob;
    endtask

    task automatic test_reset();
        clear_inputs();
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b0) begin n_err++; $display("FAIL rst_issue_valid: got %b want 0", iq.issue_valid); end
        n_cmp++; if (iq.PRF_req_A_valid !== 1'b0) begin n_err++; $display("FAIL rst_prf_valid: got %b want 0", iq.PRF_req_A_valid); end
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", iq.iq_occupancy); end
        n_cmp++; if (iq.iq_enq_ready !== 2'b11) begin n_err++; $display("FAIL rst_enq_ready: got %b want 11", iq.iq_enq_ready); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        iq.issue_ready = 1'b1;
        set_lane(1'b0, 4'h1, 12'h011, 7'h10, 1'b1, 1'b0, 7'h20, 5'd3);
        set_lane(1'b1, 4'h2, 12'h022, 7'h11, 1'b1, 1'b0, 7'h21, 5'd4);
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty_issue: got %b want 0", iq.issue_valid); end
        tick();
        clear_inputs();
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b1) begin n_err++; $display("FAIL b2b_issue0_valid: got %b want 1", iq.issue_valid); end
        n_cmp++; if (iq.issue_ROB_index !== 5'd3) begin n_err++; $display("FAIL b2b_issue0_rob: got %0d want 3", iq.issue_ROB_index); end
        n_cmp++; if (iq.issue_op !== 4'h1 || iq.issue_imm12 !== 12'h011 || iq.issue_dest_PR !== 7'h20) begin
            n_err++; $display("FAIL b2b_issue0_payload: got op %h imm %h dest %h want 1 011 20", iq.issue_op, iq.issue_imm12, iq.issue_dest_PR); end
        n_cmp++; if (iq.PRF_req_A_valid !== 1'b1 || iq.PRF_req_A_PR !== 7'h10) begin
            n_err++; $display("FAIL b2b_prf_req: got %b/%h want 1/10", iq.PRF_req_A_valid, iq.PRF_req_A_PR); end
        n_cmp++; if (iq.iq_occupancy !== 4'd2) begin n_err++; $display("FAIL b2b_occ2: got %0d want 2", iq.iq_occupancy); end
        tick();
        n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_ROB_index !== 5'd4) begin
            n_err++; $display("FAIL b2b_issue1: got %b/%0d want 1/4", iq.issue_valid, iq.issue_ROB_index); end
        n_cmp++; if (iq.iq_occupancy !== 4'd1) begin n_err++; $display("FAIL b2b_occ1: got %0d want 1", iq.iq_occupancy); end
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd0 || iq.issue_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_drained: got occ %0d valid %b want 0/0", iq.iq_occupancy, iq.issue_valid); end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            set_lane(1'b0, 4'(c), 12'(c), 7'(c), 1'b1, 1'b0, 7'(c), 5'(2 * c));
            set_lane(1'b1, 4'(c), 12'(c), 7'(c), 1'b1, 1'b0, 7'(c), 5'(2 * c + 1));
            tick();
        end
        clear_inputs();
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd10 || iq.iq_enq_ready !== 2'b11) begin
            n_err++; $display("FAIL fill_10: got occ %0d rdy %b want 10/11", iq.iq_occupancy, iq.iq_enq_ready); end
        set_lane(1'b0, 4'h5, 12'h005, 7'h05, 1'b1, 1'b0, 7'h05, 5'd10);
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd11 || iq.iq_enq_ready !== 2'b01) begin
            n_err++; $display("FAIL fill_11: got occ %0d rdy %b want 11/01", iq.iq_occupancy, iq.iq_enq_ready); end
        clear_inputs();
        set_lane(1'b0, 4'h6, 12'h006, 7'h06, 1'b1, 1'b0, 7'h06, 5'd11);
        set_lane(1'b1, 4'h6, 12'h006, 7'h06, 1'b1, 1'b0, 7'h06, 5'd12);
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd12 || iq.iq_enq_ready !== 2'b00) begin
            n_err++; $display("FAIL fill_full: got occ %0d rdy %b want 12/00", iq.iq_occupancy, iq.iq_enq_ready); end
        clear_inputs();
        set_lane(1'b0, 4'h7, 12'h007, 7'h07, 1'b1, 1'b0, 7'h07, 5'd20);
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd12) begin n_err++; $display("FAIL fill_full_drop: got occ %0d want 12", iq.iq_occupancy); end
        clear_inputs();
        iq.issue_ready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            #1;
            n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_ROB_index !== 5'(e)) begin
                n_err++; $display("FAIL fill_drain_%0d: got %b/%0d want 1/%0d", e, iq.issue_valid, iq.issue_ROB_index, e); end
            tick();
        end
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd0 || iq.issue_valid !== 1'b0) begin
            n_err++; $display("FAIL fill_empty: got occ %0d valid %b want 0/0", iq.iq_occupancy, iq.issue_valid); end
    endtask

    task automatic test_forward();
        clear_inputs();
        set_lane(1'b0, 4'h3, 12'h123, 7'h25, 1'b0, 1'b0, 7'h30, 5'd5);
        tick();
        clear_inputs();
        iq.issue_ready = 1'b1;
        iq.WB_bus_valid_by_bank = 4'b0010;
        iq.WB_bus_upper_PR_by_bank[1] = 5'h08;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b0) begin n_err++; $display("FAIL fwd_wrong_upper: got %b want 0", iq.issue_valid); end
        iq.WB_bus_upper_PR_by_bank[1] = 5'h09;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_ROB_index !== 5'd5 || iq.issue_imm12 !== 12'h123) begin
            n_err++; $display("FAIL fwd_issue: got %b/%0d/%h want 1/5/123", iq.issue_valid, iq.issue_ROB_index, iq.issue_imm12); end
        n_cmp++; if (iq.issue_A_forward !== 1'b1 || iq.PRF_req_A_valid !== 1'b0 || iq.issue_A_bank !== 2'd1) begin
            n_err++; $display("FAIL fwd_flags: got fwd %b prf %b bank %0d want 1/0/1", iq.issue_A_forward, iq.PRF_req_A_valid, iq.issue_A_bank); end
        tick();
        clear_inputs();
        set_lane(1'b0, 4'h4, 12'h456, 7'h25, 1'b0, 1'b0, 7'h31, 5'd6);
        tick();
        clear_inputs();
        iq.WB_bus_valid_by_bank = 4'b0010;
        iq.WB_bus_upper_PR_by_bank[1] = 5'h09;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd1 || iq.issue_valid !== 1'b0) begin
            n_err++; $display("FAIL fwd_hold: got occ %0d valid %b want 1/0", iq.iq_occupancy, iq.issue_valid); end
        tick();
        clear_inputs();
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_A_forward !== 1'b0 || iq.PRF_req_A_valid !== 1'b1 || iq.PRF_req_A_PR !== 7'h25) begin
            n_err++; $display("FAIL fwd_captured: got v %b fwd %b prf %b pr %h want 1/0/1/25", iq.issue_valid, iq.issue_A_forward, iq.PRF_req_A_valid, iq.PRF_req_A_PR); end
        tick();
        clear_inputs();
        set_lane(1'b0, 4'h5, 12'h000, 7'h00, 1'b0, 1'b1, 7'h32, 5'd7);
        tick();
        clear_inputs();
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_A_is_zero !== 1'b1 || iq.PRF_req_A_valid !== 1'b0) begin
            n_err++; $display("FAIL fwd_zero: got v %b z %b prf %b want 1/1/0", iq.issue_valid, iq.issue_A_is_zero, iq.PRF_req_A_valid); end
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL fwd_empty: got %0d want 0", iq.iq_occupancy); end
    endtask

    task automatic test_kill();
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            iq.rob_head_index = 5'd8;
            set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'(10 + 2 * c));
            set_lane(1'b1, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'(11 + 2 * c));
            tick();
        end
        clear_inputs();
        iq.rob_head_index = 5'd8;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd6) begin n_err++; $display("FAIL kill_pre_occ: got %0d want 6", iq.iq_occupancy); end
        iq.kill_valid = 1'b1;
        iq.kill_ROB_index = 5'd12;
        set_lane(1'b0, 4'h2, 12'h002, 7'h02, 1'b1, 1'b0, 7'h02, 5'd20);
        set_lane(1'b1, 4'h2, 12'h002, 7'h02, 1'b1, 1'b0, 7'h02, 5'd21);
        tick();
        clear_inputs();
        iq.rob_head_index = 5'd8;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd2 || iq.iq_enq_ready !== 2'b11) begin
            n_err++; $display("FAIL kill_post_occ: got occ %0d rdy %b want 2/11", iq.iq_occupancy, iq.iq_enq_ready); end
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_ROB_index !== 5'd10) begin
            n_err++; $display("FAIL kill_keep10: got %b/%0d want 1/10", iq.issue_valid, iq.issue_ROB_index); end
        tick();
        n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_ROB_index !== 5'd11) begin
            n_err++; $display("FAIL kill_keep11: got %b/%0d want 1/11", iq.issue_valid, iq.issue_ROB_index); end
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL kill_drained: got %0d want 0", iq.iq_occupancy); end
        clear_inputs();
        iq.rob_head_index = 5'd8;
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd10);
        set_lane(1'b1, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd11);
        tick();
        clear_inputs();
        iq.rob_head_index = 5'd8;
        iq.kill_valid = 1'b1;
        iq.kill_ROB_index = 5'd10;
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.issue_valid !== 1'b0) begin n_err++; $display("FAIL kill_no_issue: got %b want 0", iq.issue_valid); end
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL kill_all: got %0d want 0", iq.iq_occupancy); end
    endtask

    task automatic test_rob_wrap();
        clear_inputs();
        iq.rob_head_index = 5'd30;
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd31);
        set_lane(1'b1, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd0);
        tick();
        clear_inputs();
        iq.rob_head_index = 5'd30;
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd1);
        tick();
        clear_inputs();
        iq.rob_head_index = 5'd30;
        iq.kill_valid = 1'b1;
        iq.kill_ROB_index = 5'd0;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd3) begin n_err++; $display("FAIL wrap_pre_occ: got %0d want 3", iq.iq_occupancy); end
        tick();
        clear_inputs();
        iq.rob_head_index = 5'd30;
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd1 || iq.issue_ROB_index !== 5'd31 || iq.issue_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_keep31: got occ %0d v %b rob %0d want 1/1/31", iq.iq_occupancy, iq.issue_valid, iq.issue_ROB_index); end
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL wrap_empty: got %0d want 0", iq.iq_occupancy); end
    endtask

    task automatic test_issue_with_enq();
        clear_inputs();
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd1);
        set_lane(1'b1, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd2);
        tick();
        clear_inputs();
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd3);
        tick();
        clear_inputs();
        iq.issue_ready = 1'b1;
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd4);
        set_lane(1'b1, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd5);
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd3 || iq.issue_ROB_index !== 5'd1 || iq.issue_valid !== 1'b1) begin
            n_err++; $display("FAIL iwe_issue1: got occ %0d v %b rob %0d want 3/1/1", iq.iq_occupancy, iq.issue_valid, iq.issue_ROB_index); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd4) begin n_err++; $display("FAIL iwe_occ4: got %0d want 4", iq.iq_occupancy); end
        iq.issue_ready = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            #1;
            n_cmp++; if (iq.issue_valid !== 1'b1 || iq.issue_ROB_index !== 5'(e)) begin
                n_err++; $display("FAIL iwe_order_%0d: got %b/%0d want 1/%0d", e, iq.issue_valid, iq.issue_ROB_index, e); end
            tick();
        end
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL iwe_empty: got %0d want 0", iq.iq_occupancy); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_lane(1'b0, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd9);
        set_lane(1'b1, 4'h1, 12'h001, 7'h01, 1'b1, 1'b0, 7'h01, 5'd10);
        tick();
        clear_inputs();
        iq.issue_ready = 1'b1;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd2) begin n_err++; $display("FAIL mid_pre_occ: got %0d want 2", iq.iq_occupancy); end
        nRST = 1'b0;
        #1;
        n_cmp++; if (iq.iq_occupancy !== 4'd0 || iq.issue_valid !== 1'b0 || iq.iq_enq_ready !== 2'b11) begin
            n_err++; $display("FAIL mid_reset: got occ %0d v %b rdy %b want 0/0/11", iq.iq_occupancy, iq.issue_valid, iq.iq_enq_ready); end
        #1;
        nRST = 1'b1;
        tick();
        n_cmp++; if (iq.iq_occupancy !== 4'd0) begin n_err++; $display("FAIL mid_after: got %0d want 0", iq.iq_occupancy); end
    endtask

    initial begin
        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        test_reset();
        test_back_to_back();
        test_fill();
        test_forward();
        test_kill();
        test_rob_wrap();
        test_issue_with_enq();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
